ff_excitation_gen: RTL
======================

// Module: ff_excitation_gen
// PURPOSE
//  Inverse of the SR/JK/T/D flip-flop blocks: takes a stream of desired next-q
//  bits and generates the excitation inputs (S/R, J/K, T or D) that move an
//  external flip-flop on the same clk to that state.
//  Reads the flip-flop's q back after each transfer and flags mismatches.
//  Used as a self-checking stimulus engine for flip-flop conversion designs.
// PARAMETERS
//  CNT_W   8  width of err_cnt (saturating mismatch counter)
//  SETTLE  1  WAIT cycles after the drive cycle before ff_q is compared (>=1)
// PORTS
//  clk        in   1      rising-edge clock, shared with the driven flip-flop
//  rst        in   1      asynchronous, active-high reset
//  mode       in   2      00=SR 01=JK 10=T 11=D; sampled on accept
//  tgt_valid  in   1      tgt_bit is valid
//  tgt_bit    in   1      desired next q of the driven flip-flop
//  tgt_ready  out  1      high in IDLE; a transfer is accepted on valid&ready
//  ff_q       in   1      q fed back from the driven flip-flop
//  s_j        out  1      S (SR), J (JK), D (D mode); 0 in T mode
//  r_k        out  1      R (SR), K (JK); 0 in T/D mode
//  t          out  1      T (T mode); 0 otherwise
//  chk_valid  out  1      one-cycle pulse: comparison result available
//  chk_ok     out  1      ff_q matched target; valid while chk_valid=1
//  err_cnt    out  CNT_W  count of mismatches, saturates at all-ones
//  busy       out  1      ~tgt_ready
// BEHAVIOUR
//  Reset (async): state=IDLE; s_j,r_k,t,chk_valid,chk_ok=0; err_cnt=0; D-hold reg=0.
//  FSM: IDLE -> DRIVE (on accept) -> WAIT (SETTLE cycles) -> IDLE (with chk pulse).
//  Accept edge E0: latch mode, tgt_bit, q0=ff_q; register excitation onto outputs.
//  Excitation (q0 -> tgt), don't-cares resolved to 0:
//   SR: 0->1 (1,0); 1->0 (0,1); hold (0,0). S=R=1 is never driven.
//   JK: same as SR; J=K=1 is never driven.
//   T : t = q0 ^ tgt.   D: s_j = tgt.
//  DRIVE is exactly one cycle (E0..E1); the flip-flop samples at E1.
//  At E1 outputs return to hold values: SR/JK (0,0); T 0; D s_j keeps last tgt.
//  WAIT lasts SETTLE cycles; at edge E(1+SETTLE): chk_ok=(ff_q==tgt),
//   chk_valid=1 for one cycle, err_cnt+=~chk_ok (saturating), state=IDLE.
//  Latency accept edge -> chk_valid rise = 1+SETTLE cycles; next accept is
//   possible no earlier than edge E(2+SETTLE).
//  tgt_valid while busy is not accepted; mode/tgt_bit changes while busy are ignored.
//  Idle outputs never pulse the flip-flop.
//  Reset mid-transfer: transfer dropped, no chk_valid, all outputs to reset values.
//  err_cnt at all-ones stays all-ones on further mismatches; no wrap.
// TESTING
//  1 rst=1 during WAIT -> outputs/err_cnt 0 immediately, no chk_valid, tgt_ready=1 after release.
//  2 SR, ideal SR FF from q=0, targets 1,1,0,0 -> DRIVE (s_j,r_k)=(1,0),(0,0),(0,1),(0,0); chk_ok=1 x4; err_cnt=0.
//  3 JK, targets 1,0,1,1 -> (1,0),(0,1),(1,0),(0,0); never both high in any cycle.
//  4 T, targets 1,0,0,1 from q=0 -> t=1,1,0,1 in DRIVE, t=0 elsewhere; D mode: s_j tracks tgt and holds.
//  5 ff_q tied 0, CNT_W=2, target 1 x5 -> chk_ok=0 each; err_cnt 1,2,3,3,3.
//  6 SETTLE=3, tgt_valid held high -> chk_valid 4 cycles after each accept; accepts spaced 5 cycles.

Source files
------------

// File: rtl/ff_excitation_gen.sv
// Excitation generator that drives an external SR/JK/T/D flip-flop to a desired next q,
// then reads q back after a settle window and reports match/mismatch.
module ff_excitation_gen #(
    parameter int CNT_W  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    input  logic             ff_q,
    output logic             s_j,
    output logic             r_k,
    output logic             t,
    output logic             chk_valid,
    output logic             chk_ok,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_T  = 2'b10;
    localparam logic [1:0] MODE_D  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        WAIT
    } state_t;

    state_t             state, state_next;
    logic [1:0]         mode_q, mode_next;
    logic               tgt_q, tgt_next;
    logic [WAIT_W-1:0]  wait_cnt, wait_next;
    logic               s_j_next, r_k_next, t_next;
    logic               chk_valid_next, chk_ok_next;
    logic [CNT_W-1:0]   err_next;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_next     = state;
        mode_next      = mode_q;
        tgt_next       = tgt_q;
        wait_next      = wait_cnt;
        s_j_next       = s_j;
        r_k_next       = r_k;
        t_next         = t;
        chk_valid_next = 1'b0;
        chk_ok_next    = chk_ok;
        err_next       = err_cnt;

        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    state_next = DRIVE;
                    mode_next  = mode;
                    tgt_next   = tgt_bit;
                    s_j_next   = 1'b0;
                    r_k_next   = 1'b0;
                    t_next     = 1'b0;
                    // Don't-care excitation terms resolve to 0, so S=R=1 / J=K=1 never occur.
                    case (mode)
                        MODE_SR, MODE_JK: begin
                            s_j_next = tgt_bit & ~ff_q;
                            r_k_next = ~tgt_bit & ff_q;
                        end
                        MODE_T:  t_next   = tgt_bit ^ ff_q;
                        default: s_j_next = tgt_bit;
                    endcase
                end
            end

            DRIVE: begin
                state_next = WAIT;
                wait_next  = WAIT_W'(SETTLE - 1);
                r_k_next   = 1'b0;
                t_next     = 1'b0;
                // A D flip-flop resamples every edge, so D mode keeps presenting the target.
                if (mode_q != MODE_D) begin
                    s_j_next = 1'b0;
                end
            end

            WAIT: begin
                if (wait_cnt == '0) begin
                    state_next     = IDLE;
                    chk_valid_next = 1'b1;
                    chk_ok_next    = (ff_q == tgt_q);
                    if ((ff_q != tgt_q) && (err_cnt != '1)) begin
                        err_next = err_cnt + CNT_W'(1);
                    end
                end else begin
                    wait_next = wait_cnt - WAIT_W'(1);
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= MODE_SR;
            tgt_q     <= 1'b0;
            wait_cnt  <= '0;
            s_j       <= 1'b0;
            r_k       <= 1'b0;
            t         <= 1'b0;
            chk_valid <= 1'b0;
            chk_ok    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state     <= state_next;
            mode_q    <= mode_next;
            tgt_q     <= tgt_next;
            wait_cnt  <= wait_next;
            s_j       <= s_j_next;
            r_k       <= r_k_next;
            t         <= t_next;
            chk_valid <= chk_valid_next;
            chk_ok    <= chk_ok_next;
            err_cnt   <= err_next;
        end
    end

    assign tgt_ready = (state == IDLE);
    assign busy      = ~tgt_ready;

endmodule
